// File: rtl/lab62soc_spi_slave.sv
// SPI mode-0 slave with a small CPU-facing register file (rxdata/txdata/status/control).
// Optional interrupt logic is built only when LAB62_SPISLV_IRQ_EN is defined.
module lab62soc_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  // IDLE: SS_n high | LOAD: preload TX one cycle after SS_n fall | SHIFT: bits moving
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic                   r_sclk_d, r_ss_d;
  logic                   w_sclk, w_mosi, w_ss;
  logic                   w_sclk_rise, w_sclk_fall, w_ss_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_ss) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_LOAD;
        ST_LOAD:  w_state_nxt = ST_SHIFT;
        ST_SHIFT: w_state_nxt = ST_SHIFT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  logic       w_idle, w_load, w_rx_en, w_tx_shift, w_byte_done;
  logic [2:0] r_bitcnt;
  logic       r_byte_end;

  always_comb begin
    w_idle     = 1'b0;
    w_load     = 1'b0;
    w_rx_en    = 1'b0;
    w_tx_shift = 1'b0;
    case (r_state)
      ST_IDLE: w_idle = 1'b1;
      ST_LOAD: w_load = ~w_ss;
      ST_SHIFT: begin
        if (!w_ss) begin
          w_rx_en = w_sclk_rise;
          // The falling edge that closes a byte reloads instead of shifting.
          if (w_sclk_fall) begin
            w_load     = r_byte_end;
            w_tx_shift = ~r_byte_end;
          end
        end
      end
      default: w_idle = 1'b1;
    endcase
  end

  assign w_byte_done = w_rx_en & (r_bitcnt == 3'(DATABITS - 1));

  logic                w_rd, w_wr, r_rd_skip, r_wr_skip;
  logic                w_rd_rx, w_wr_tx, w_wr_st, w_wr_ctl, w_rx_clr, w_tx_accept;
  logic [DATABITS-1:0] r_rx_shift, r_rx_holding, r_tx_shift, r_tx_holding;
  logic                r_primed, r_rrdy, r_roe, r_toe, r_ur;
  logic [15:0]         w_status, w_ctrl;

  assign w_rd        = spi_select & ~read_n & ~r_rd_skip;
  assign w_wr        = spi_select & ~write_n & ~r_wr_skip;
  assign w_rd_rx     = w_rd & (mem_addr == 3'd0);
  assign w_wr_tx     = w_wr & (mem_addr == 3'd1);
  assign w_wr_st     = w_wr & (mem_addr == 3'd2);
  assign w_wr_ctl    = w_wr & (mem_addr == 3'd3);
  assign w_rx_clr    = w_rd_rx | w_wr_st;
  // A load in the same cycle frees the holding register, so the write is kept.
  assign w_tx_accept = w_wr_tx & (~r_primed | w_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt   <= '0;
      r_byte_end <= 1'b0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      if (w_idle || r_state == ST_LOAD) begin
        r_bitcnt   <= '0;
        r_byte_end <= 1'b0;
        r_rx_shift <= '0;
      end else if (w_rx_en) begin
        r_rx_shift <= {r_rx_shift[DATABITS-2:0], w_mosi};
        r_bitcnt   <= r_bitcnt + 3'd1;
        r_byte_end <= w_byte_done;
      end else if (w_load) begin
        r_byte_end <= 1'b0;
      end
      if (w_load)          r_tx_shift <= r_primed ? r_tx_holding : '0;
      else if (w_tx_shift) r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_skip    <= 1'b0;
      r_wr_skip    <= 1'b0;
      r_rx_holding <= '0;
      r_tx_holding <= '0;
      r_primed     <= 1'b0;
      r_rrdy       <= 1'b0;
      r_roe        <= 1'b0;
      r_toe        <= 1'b0;
      r_ur         <= 1'b0;
      data_to_cpu  <= '0;
    end else begin
      r_rd_skip <= w_rd;
      r_wr_skip <= w_wr;
      if (w_byte_done) r_rx_holding <= {r_rx_shift[DATABITS-2:0], w_mosi};
      if (w_byte_done)   r_rrdy <= 1'b1;
      else if (w_rx_clr) r_rrdy <= 1'b0;
      if (w_byte_done && r_rrdy && !w_rx_clr) r_roe <= 1'b1;
      else if (w_wr_st)                       r_roe <= 1'b0;
      if (w_wr_tx && !w_tx_accept) r_toe <= 1'b1;
      else if (w_wr_st)            r_toe <= 1'b0;
      if (w_load && !r_primed) r_ur <= 1'b1;
      else if (w_wr_st)        r_ur <= 1'b0;
      if (w_tx_accept) begin
        r_tx_holding <= data_from_cpu[DATABITS-1:0];
        r_primed     <= 1'b1;
      end else if (w_load) begin
        r_primed <= 1'b0;
      end
      if (w_rd) begin
        case (mem_addr)
          3'd0:    data_to_cpu <= {{(16-DATABITS){1'b0}}, r_rx_holding};
          3'd2:    data_to_cpu <= w_status;
          3'd3:    data_to_cpu <= w_ctrl;
          default: data_to_cpu <= '0;
        endcase
      end
    end
  end

  assign w_status = {7'b0, r_toe | r_roe | r_ur, r_rrdy, ~r_primed,
                     ~r_primed & (r_state == ST_IDLE), r_toe, r_roe, r_ur, 2'b00};

  logic w_unused;
`ifdef LAB62_SPISLV_IRQ_EN
  logic [15:0] r_ctrl;
  logic        r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_ctl) r_ctrl <= data_from_cpu & 16'h01DC;
      r_irq <= |(w_status & r_ctrl);
    end
  end

  assign w_ctrl   = r_ctrl;
  assign irq      = r_irq;
  assign w_unused = 1'b0;
`else
  assign w_ctrl   = '0;
  assign irq      = 1'b0;
  assign w_unused = ^{data_from_cpu[15:DATABITS], w_wr_ctl};
`endif

  assign MISO          = ~w_ss & r_tx_shift[DATABITS-1];
  assign MISO_oe       = ~w_ss;
  assign dataavailable = r_rrdy;
  assign readyfordata  = ~r_primed;

endmodule

// File: tb/tb_lab62soc_spi_slave.sv
// Self-checking bench for lab62soc_spi_slave: directed and random SPI frames
// compared against a flag-level reference model of the register file.
module tb_lab62soc_spi_slave;
  logic        clk = 1'b0, reset = 1'b1;
  logic        SCLK = 1'b0, MOSI = 1'b0, SS_n = 1'b1;
  logic        MISO, MISO_oe, irq, dataavailable, readyfordata;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0, data_to_cpu;
  logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;

  int errors = 0, checks = 0;

  lab62soc_spi_slave dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #10 clk = ~clk;

`ifdef LAB62_SPISLV_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  // reference model state
  logic [7:0]  m_hold, m_rx, cur;
  logic        m_primed, m_rrdy, m_roe, m_toe, m_ur, m_ss_low;
  logic [15:0] m_ctrl;
  logic [7:0]  mo [4];

  function automatic logic [15:0] exp_status();
    logic e;
    e = m_toe | m_roe | m_ur;
    return {7'b0, e, m_rrdy, ~m_primed, ~m_primed & ~m_ss_low, m_toe, m_roe, m_ur, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_hold = 0; m_rx = 0; m_primed = 0; m_rrdy = 0; m_roe = 0;
    m_toe = 0; m_ur = 0; m_ss_low = 0; m_ctrl = 0;
  endtask

  task automatic m_load();
    if (m_primed) begin cur = m_hold; m_primed = 0; end
    else begin cur = 8'h00; m_ur = 1; end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    @(negedge clk);
    spi_select = 0; write_n = 1;
    @(negedge clk);
    case (a)
      3'd1: if (!m_primed) begin m_hold = d[7:0]; m_primed = 1; end else m_toe = 1;
      3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_ur = 0; end
      3'd3: m_ctrl = IRQ_BUILD ? (d & 16'h01DC) : 16'h0;
      default: ;
    endcase
  endtask

  task automatic rd_check(input logic [2:0] a, input string tag);
    logic [15:0] exp;
    case (a)
      3'd0: exp = {8'h00, m_rx};
      3'd2: exp = exp_status();
      3'd3: exp = m_ctrl;
      default: exp = 16'h0;
    endcase
    spi_select = 1; read_n = 0; mem_addr = a;
    @(negedge clk);
    check(tag, data_to_cpu, exp);
    @(negedge clk);
    spi_select = 0; read_n = 1;
    @(negedge clk);
    if (a == 3'd0) m_rrdy = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_rrdy"}, {15'h0, dataavailable}, {15'h0, m_rrdy});
    check({tag, "_trdy"}, {15'h0, readyfordata}, {15'h0, ~m_primed});
  endtask

  // Master: MOSI changes while SCLK low, MISO sampled at the rising edge.
  task automatic spi_frame(input int nbytes, input int abort_bits, input bit keep_ss);
    logic [7:0] got;
    int nb;
    SS_n = 0; m_ss_low = 1;
    repeat (16) @(negedge clk);
    m_load();
    check("miso_oe_low_ss", {15'h0, MISO_oe}, 16'h0001);
    for (int k = 0; k < nbytes; k++) begin
      got = 8'h00;
      nb = (abort_bits != 0 && k == nbytes - 1) ? abort_bits : 8;
      for (int i = 0; i < nb; i++) begin
        MOSI = mo[k][7-i];
        repeat (8) @(negedge clk);
        SCLK = 1; got[7-i] = MISO;
        repeat (8) @(negedge clk);
        SCLK = 0;
      end
      if (nb == 8) begin
        check("miso_byte", {8'h00, got}, {8'h00, cur});
        if (m_rrdy) m_roe = 1;
        m_rrdy = 1; m_rx = mo[k];
        m_load();
      end
    end
    MOSI = 0;
    repeat (8) @(negedge clk);
    if (!keep_ss) begin
      SS_n = 1; m_ss_low = 0;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] v1, v2;
    int n;
    m_reset(); cur = 0;
    repeat (4) @(negedge clk);
    check("rst_dout", data_to_cpu, 16'h0000);
    check("rst_miso", {14'h0, MISO_oe, MISO}, 16'h0000);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    reset = 0;
    @(negedge clk);
    check_flags("rst");
    rd_check(3'd2, "rst_status");

    // known byte exchange
    bus_write(3'd1, 16'h00A5);
    mo[0] = 8'h3C;
    spi_frame(1, 0, 0);
    check_flags("xfer");
    rd_check(3'd0, "rx_3c");
    check_flags("after_rx_read");
    rd_check(3'd2, "status_xfer");
    bus_write(3'd2, 16'h0);

    // two bytes without reading: overrun
    bus_write(3'd1, 16'($urandom));
    mo[0] = 8'($urandom); mo[1] = 8'($urandom);
    spi_frame(2, 0, 0);
    rd_check(3'd2, "status_overrun");
    rd_check(3'd0, "rx_second");

    // no txdata: underrun, then clear while SS_n still low
    bus_write(3'd2, 16'h0);
    mo[0] = 8'($urandom);
    spi_frame(1, 0, 1);
    rd_check(3'd2, "status_underrun");
    bus_write(3'd2, 16'h0);
    rd_check(3'd2, "status_cleared_ss_low");
    SS_n = 1; m_ss_low = 0;
    repeat (8) @(negedge clk);
    rd_check(3'd2, "status_idle");
    check("miso_ss_high", {14'h0, MISO_oe, MISO}, 16'h0000);

    // double txdata write: TOE, first value sent
    v1 = 8'($urandom); v2 = 8'($urandom);
    bus_write(3'd1, {8'h00, v1});
    bus_write(3'd1, {8'h00, v2});
    rd_check(3'd2, "status_toe");
    mo[0] = 8'($urandom);
    spi_frame(1, 0, 0);
    rd_check(3'd0, "rx_toe_frame");
    bus_write(3'd2, 16'h0);

    // abort after 4 bits, then a full frame
    mo[0] = 8'($urandom);
    spi_frame(1, 4, 0);
    check_flags("abort");
    bus_write(3'd1, 16'($urandom));
    mo[0] = 8'($urandom);
    spi_frame(1, 0, 0);
    rd_check(3'd0, "rx_after_abort");
    bus_write(3'd2, 16'h0);

    // random traffic
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) mo[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) bus_write(3'd1, 16'($urandom));
      if ($urandom_range(0, 3) == 0) bus_write(3'd1, 16'($urandom));
      spi_frame(n, 0, 0);
      check_flags("rand");
      rd_check(3'd2, "status_rand");
      if ($urandom_range(0, 1) == 1) rd_check(3'd0, "rx_rand");
      if ($urandom_range(0, 2) == 0) bus_write(3'd2, 16'h0);
    end

    // interrupt on RRDY
    bus_write(3'd2, 16'h0);
    rd_check(3'd0, "rx_drain");
    bus_write(3'd3, 16'hFF80);
    rd_check(3'd3, "ctrl_readback");
    bus_write(3'd1, 16'($urandom));
    mo[0] = 8'($urandom);
    fork
      spi_frame(1, 0, 0);
      begin : irq_mon
        int w;
        w = 0;
        while (!dataavailable && w < 4000) begin @(negedge clk); w++; end
        check("irq_rrdy_seen", {15'h0, dataavailable}, 16'h0001);
        check("irq_same_cycle", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        check("irq_next_cycle", {15'h0, irq}, {15'h0, IRQ_BUILD});
      end
    join
    rd_check(3'd0, "rx_irq_frame");
    @(negedge clk);
    check("irq_cleared", {15'h0, irq}, 16'h0000);

    // reset in the middle of a frame
    bus_write(3'd1, 16'($urandom));
    SS_n = 0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'($urandom);
      repeat (8) @(negedge clk); SCLK = 1;
      repeat (8) @(negedge clk); SCLK = 0;
    end
    reset = 1;
    m_reset();
    repeat (3) @(negedge clk);
    check("midrst_dout", data_to_cpu, 16'h0000);
    SS_n = 1;
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (8) @(negedge clk);
    rd_check(3'd2, "status_after_midrst");
    bus_write(3'd1, 16'($urandom));
    mo[0] = 8'($urandom);
    spi_frame(1, 0, 0);
    rd_check(3'd0, "rx_after_midrst");
    rd_check(3'd2, "status_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
